// File: rtl/noc_rr_arbiter.sv
// Round-robin output-port arbiter for the NoC router.
// Picks one requesting input port as the owner of this output, drives the
// crossbar select for it and runs the RTS/DCTS handshake with the downstream
// router. Priority rotates from the last owner. An optional hold limit forces
// rotation after MAX_HOLD consecutive transfers when other ports are waiting.
module noc_rr_arbiter #(
  parameter int N_PORTS  = 5,
  parameter int MAX_HOLD = 0,
  parameter int IDX_W    = $clog2(N_PORTS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] req,
  input  logic               dcts,
  output logic [N_PORTS-1:0] grant,
  output logic [N_PORTS-1:0] xbar_sel,
  output logic [IDX_W-1:0]   owner_idx,
  output logic               owner_valid,
  output logic               rts
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_PORTS - 1);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  owner_n;
  logic [IDX_W-1:0]  last_ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic              xfer;
  logic              stall;
  logic              keep;
  logic              found;
  logic [IDX_W-1:0]  start;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  cand;
  int                cand_int;

  assign xfer  = rts & dcts;
  assign stall = rts & ~dcts;

  // Cyclic search for the first requester after the start index; the start
  // index itself is visited last, so a lone owner can be picked again.
  always_comb begin
    start    = (state == IDLE) ? last_ptr : owner;
    found    = 1'b0;
    pick     = '0;
    cand_int = 0;
    cand     = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      cand_int = (int'(start) + i) % N_PORTS;
      cand     = cand_int[IDX_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next owner: keep the current one while it requests and is under the
  // hold limit, otherwise take the search result, otherwise go idle.
  always_comb begin
    keep    = (state == OWNED) && req[owner] &&
              ((MAX_HOLD == 0) || (hold_cnt < HOLD_LIMIT));
    state_n = IDLE;
    owner_n = '0;
    if (keep) begin
      state_n = OWNED;
      owner_n = owner;
    end else if (found) begin
      state_n = OWNED;
      owner_n = pick;
    end
  end

  // Owner, handshake, hold counter and rotation pointer; everything freezes
  // while a request-to-send waits for clear-to-send. rts is only raised when
  // an owner exists both now and after this edge, so releasing a port that
  // dropped its request never leaves rts asserted without an owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rts      <= 1'b0;
      hold_cnt <= '0;
      last_ptr <= LAST_IDX;
    end else if (!stall) begin
      state <= state_n;
      owner <= owner_n;
      rts   <= (state == OWNED) && (state_n == OWNED) && !xfer;
      if ((state == OWNED) && ((state_n == IDLE) || (owner_n != owner))) begin
        hold_cnt <= '0;
        last_ptr <= owner;
      end else if (xfer && (MAX_HOLD != 0) && (hold_cnt != HOLD_LIMIT)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // Crossbar select follows the owner; grant marks the transfer cycle only.
  always_comb begin
    xbar_sel = '0;
    if (state == OWNED) begin
      xbar_sel[owner] = 1'b1;
    end
    grant = xfer ? xbar_sel : '0;
  end

  assign owner_idx   = owner;
  assign owner_valid = (state == OWNED);

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Directed bench for noc_rr_arbiter: reset, single request latency, stall,
// round robin, hold limit, asynchronous reset and a randomised invariant and
// starvation sweep across N_PORTS = 2, 5 and 16.
module tb_noc_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Sweep slot 0: N=2/MAX_HOLD=1, slot 1: main N=5/MAX_HOLD=0, slot 2: N=16/MAX_HOLD=1.
  logic [15:0] rq  [3];
  logic        dc  [3];
  logic [15:0] g_s [3];
  logic [15:0] x_s [3];
  logic [3:0]  i_s [3];
  logic        v_s [3];
  logic        r_s [3];

  logic [1:0]  grant2, xbar2;
  logic [0:0]  idx2;
  logic        valid2, rts2;
  logic [4:0]  grant5, xbar5;
  logic [2:0]  idx5;
  logic        valid5, rts5;
  logic [15:0] grant16, xbar16;
  logic [3:0]  idx16;
  logic        valid16, rts16;

  logic [4:0]  req_h, grant_h, xbar_h;
  logic [2:0]  idx_h;
  logic        dcts_h, valid_h, rts_h;

  noc_rr_arbiter #(.N_PORTS(2), .MAX_HOLD(1)) dut2 (
    .clk(clk), .rst(rst), .req(rq[0][1:0]), .dcts(dc[0]),
    .grant(grant2), .xbar_sel(xbar2), .owner_idx(idx2),
    .owner_valid(valid2), .rts(rts2)
  );

  noc_rr_arbiter #(.N_PORTS(5), .MAX_HOLD(0)) dut (
    .clk(clk), .rst(rst), .req(rq[1][4:0]), .dcts(dc[1]),
    .grant(grant5), .xbar_sel(xbar5), .owner_idx(idx5),
    .owner_valid(valid5), .rts(rts5)
  );

  noc_rr_arbiter #(.N_PORTS(16), .MAX_HOLD(1)) dut16 (
    .clk(clk), .rst(rst), .req(rq[2]), .dcts(dc[2]),
    .grant(grant16), .xbar_sel(xbar16), .owner_idx(idx16),
    .owner_valid(valid16), .rts(rts16)
  );

  noc_rr_arbiter #(.N_PORTS(5), .MAX_HOLD(2)) dut_h (
    .clk(clk), .rst(rst), .req(req_h), .dcts(dcts_h),
    .grant(grant_h), .xbar_sel(xbar_h), .owner_idx(idx_h),
    .owner_valid(valid_h), .rts(rts_h)
  );

  assign g_s[0] = {14'b0, grant2};
  assign x_s[0] = {14'b0, xbar2};
  assign i_s[0] = {3'b0, idx2};
  assign v_s[0] = valid2;
  assign r_s[0] = rts2;
  assign g_s[1] = {11'b0, grant5};
  assign x_s[1] = {11'b0, xbar5};
  assign i_s[1] = {1'b0, idx5};
  assign v_s[1] = valid5;
  assign r_s[1] = rts5;
  assign g_s[2] = grant16;
  assign x_s[2] = xbar16;
  assign i_s[2] = idx16;
  assign v_s[2] = valid16;
  assign r_s[2] = rts16;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  // Drives the main 5-port arbiter for one cycle, sampling at the falling edge.
  task automatic applyStimulus(input logic [4:0] r, input logic d);
    @(posedge clk);
    #1;
    rq[1] = {11'b0, r};
    dc[1] = d;
    @(negedge clk);
  endtask

  // Drives the hold-limited arbiter for one cycle.
  task automatic applyHold(input logic [4:0] r, input logic d);
    @(posedge clk);
    #1;
    req_h  = r;
    dcts_h = d;
    @(negedge clk);
  endtask

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int          nports [3];
  int          dropp  [3];
  int          bound  [3];
  int          waitc  [3][16];
  int          maxw   [3];
  int          xfers  [3];
  logic [15:0] lastg  [3];
  int          seq    [8];
  int          cnt;
  int          others;
  int          n;
  int          gi;
  logic [4:0]  exp_vec;
  string       tag_s;

  // Directed scenarios followed by the randomised sweep.
  initial begin
    for (int s = 0; s < 3; s++) begin
      rq[s]    = '0;
      dc[s]    = 1'b0;
      maxw[s]  = 0;
      xfers[s] = 0;
      lastg[s] = '0;
      for (int i = 0; i < 16; i++) waitc[s][i] = 0;
    end
    req_h  = '0;
    dcts_h = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    checkOutput("rst_grant", 32'(grant5), 32'h0);
    checkOutput("rst_xbar",  32'(xbar5),  32'h0);
    checkOutput("rst_idx",   32'(idx5),   32'h0);
    checkOutput("rst_valid", 32'(valid5), 32'h0);
    checkOutput("rst_rts",   32'(rts5),   32'h0);

    // Single requester on port 0 with dcts held high.
    @(posedge clk);
    #1;
    rst   = 1'b0;
    rq[1] = 16'h0001;
    dc[1] = 1'b1;
    @(negedge clk);
    checkOutput("single_c0_grant", 32'(grant5), 32'h0);
    applyStimulus(5'b00001, 1'b1);
    checkOutput("single_c1_grant", 32'(grant5), 32'h0);
    checkOutput("single_c1_xbar",  32'(xbar5),  32'h1);
    checkOutput("single_c1_idx",   32'(idx5),   32'h0);
    checkOutput("single_c1_rts",   32'(rts5),   32'h0);
    applyStimulus(5'b00001, 1'b1);
    checkOutput("single_c2_grant", 32'(grant5), 32'h1);
    checkOutput("single_c2_rts",   32'(rts5),   32'h1);
    applyStimulus(5'b00001, 1'b1);
    checkOutput("single_c3_grant", 32'(grant5), 32'h0);
    applyStimulus(5'b00001, 1'b1);
    checkOutput("single_c4_grant", 32'(grant5), 32'h1);
    applyStimulus(5'b00000, 1'b1);
    checkOutput("single_c5_valid", 32'(valid5), 32'h1);
    checkOutput("single_c5_rts",   32'(rts5),   32'h0);
    applyStimulus(5'b00000, 1'b1);
    checkOutput("single_c6_valid", 32'(valid5), 32'h0);
    checkOutput("single_c6_xbar",  32'(xbar5),  32'h0);

    // Stall: owner 2 waits four cycles for dcts, request dropped while pending.
    applyStimulus(5'b00100, 1'b0);
    applyStimulus(5'b00100, 1'b0);
    checkOutput("stall_own_idx",  32'(idx5),  32'h2);
    checkOutput("stall_own_xbar", 32'(xbar5), 32'h4);
    checkOutput("stall_own_rts",  32'(rts5),  32'h0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(5'b00100, 1'b0);
      checkOutput($sformatf("stall%0d_rts", c),   32'(rts5),   32'h1);
      checkOutput($sformatf("stall%0d_grant", c), 32'(grant5), 32'h0);
      checkOutput($sformatf("stall%0d_idx", c),   32'(idx5),   32'h2);
    end
    applyStimulus(5'b00000, 1'b1);
    checkOutput("stall_release_grant", 32'(grant5), 32'h4);
    applyStimulus(5'b00000, 1'b1);
    checkOutput("stall_after_rts",   32'(rts5),   32'h0);
    checkOutput("stall_after_valid", 32'(valid5), 32'h0);

    // Round robin from a fresh reset: owners 0,1,2,3,4,0.
    @(posedge clk);
    #1;
    rst   = 1'b1;
    rq[1] = '0;
    dc[1] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_vec = 5'(1 << (k % 5));
      n = 0;
      applyStimulus(5'b11111, 1'b1);
      while (grant5 == 5'b0 && n < 8) begin
        applyStimulus(5'b11111, 1'b1);
        n++;
      end
      checkOutput($sformatf("rr_round%0d_grant", k), 32'(grant5), 32'(exp_vec));
      n = 0;
      applyStimulus(5'b00000, 1'b1);
      while (valid5 && n < 8) begin
        applyStimulus(5'b00000, 1'b1);
        n++;
      end
      checkOutput($sformatf("rr_round%0d_idle", k), 32'(valid5), 32'h0);
    end

    // Asynchronous reset during a transfer cycle.
    applyStimulus(5'b00010, 1'b0);
    applyStimulus(5'b00010, 1'b0);
    applyStimulus(5'b00010, 1'b0);
    checkOutput("areset_pre_rts", 32'(rts5), 32'h1);
    applyStimulus(5'b00010, 1'b1);
    checkOutput("areset_pre_grant", 32'(grant5), 32'h2);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("areset_grant", 32'(grant5), 32'h0);
    checkOutput("areset_rts",   32'(rts5),   32'h0);
    checkOutput("areset_xbar",  32'(xbar5),  32'h0);
    checkOutput("areset_valid", 32'(valid5), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("areset_c0_valid", 32'(valid5), 32'h0);
    applyStimulus(5'b00010, 1'b1);
    checkOutput("areset_c1_idx", 32'(idx5), 32'h1);
    checkOutput("areset_c1_rts", 32'(rts5), 32'h0);
    applyStimulus(5'b00010, 1'b1);
    checkOutput("areset_c2_grant", 32'(grant5), 32'h2);
    applyStimulus(5'b00000, 1'b1);
    applyStimulus(5'b00000, 1'b1);

    // Hold limit of 2 with ports 0 and 1 both requesting: 0,0,1,1,0,0,1,1.
    for (int j = 0; j < 8; j++) seq[j] = 99;
    cnt = 0;
    for (int c = 0; c < 24; c++) begin
      applyHold(5'b00011, 1'b1);
      if (grant_h != 5'b0 && cnt < 8) begin
        gi = 99;
        for (int b = 0; b < 5; b++) if (grant_h[b[2:0]]) gi = b;
        seq[cnt] = gi;
        cnt++;
      end
    end
    for (int j = 0; j < 8; j++) begin
      checkOutput($sformatf("hold_seq%0d", j), 32'(seq[j]), 32'((j >> 1) & 1));
    end

    // Lone requester keeps ownership despite the limit.
    repeat (6) applyHold(5'b00001, 1'b1);
    cnt    = 0;
    others = 0;
    for (int c = 0; c < 12; c++) begin
      applyHold(5'b00001, 1'b1);
      if (grant_h != 5'b0) cnt++;
      if (idx_h != 3'd0 || grant_h[4:1] != 4'b0) others++;
    end
    checkOutput("hold_solo_grants", 32'(cnt),    32'd6);
    checkOutput("hold_solo_owner",  32'(others), 32'd0);

    // Randomised sweep with invariants and a starvation bound in transfers.
    nports[0] = 2;  dropp[0] = 50;  bound[0] = 2 * 2;
    nports[1] = 5;  dropp[1] = 100; bound[1] = 5 * 1;
    nports[2] = 16; dropp[2] = 50;  bound[2] = 16 * 2;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
        for (int i = 0; i < nports[s]; i++) begin
          if (rq[s][i[3:0]]) begin
            if (lastg[s][i[3:0]] && ($urandom_range(99) < dropp[s])) rq[s][i[3:0]] = 1'b0;
          end else if ($urandom_range(99) < 30) begin
            rq[s][i[3:0]] = 1'b1;
          end
        end
        dc[s] = ($urandom_range(99) < 70);
      end
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        tag_s = $sformatf("n%0d", nports[s]);
        checkOutput({tag_s, "_grant_onehot"}, 32'($onehot0(g_s[s])), 32'h1);
        checkOutput({tag_s, "_grant_in_xbar"}, 32'(g_s[s] & ~x_s[s]), 32'h0);
        checkOutput({tag_s, "_rts_valid"}, 32'(r_s[s] & ~v_s[s]), 32'h0);
        checkOutput({tag_s, "_xbar_idx"}, 32'(x_s[s]),
                    v_s[s] ? (32'h1 << i_s[s]) : 32'h0);
        lastg[s] = g_s[s];
        if (g_s[s] != 16'b0) begin
          xfers[s]++;
          for (int i = 0; i < nports[s]; i++) begin
            if (g_s[s][i[3:0]]) waitc[s][i] = 0;
            else if (rq[s][i[3:0]]) waitc[s][i]++;
          end
        end
        for (int i = 0; i < nports[s]; i++) begin
          if (!rq[s][i[3:0]]) waitc[s][i] = 0;
          if (waitc[s][i] > maxw[s]) maxw[s] = waitc[s][i];
        end
      end
    end
    for (int s = 0; s < 3; s++) begin
      tag_s = $sformatf("n%0d", nports[s]);
      checkOutput({tag_s, "_starvation"}, 32'(maxw[s] <= bound[s]), 32'h1);
      checkOutput({tag_s, "_activity"}, 32'(xfers[s] > 50), 32'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
